// File: rtl/lycalo_thr_scan.sv
// rtl/lycalo_thr_scan.sv - threshold-scan sequencer driving LYCALOTHR and counting LYCALOTRG per step
// Each step settles the trigger pipeline, counts triggers over a window, then reports (threshold, count).
module lycalo_thr_scan #(
   parameter int CW         = 16,
   parameter int SETTLE_CYC = 4
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 START,
   input  logic                 ABORT,
   input  logic signed [31:0]   THR_START,
   input  logic signed [31:0]   THR_STEP,
   input  logic [15:0]          NSTEPS,
   input  logic [CW-1:0]        WINDOW,
   input  logic                 LYCALOTRG,
   output logic signed [31:0]   LYCALOTHR,
   output logic                 RES_VALID,
   input  logic                 RES_READY,
   output logic signed [31:0]   RES_THR,
   output logic [CW-1:0]        RES_COUNT,
   output logic                 BUSY,
   output logic                 DONE
);

   localparam int SW = $clog2(SETTLE_CYC + 1);
   localparam int TW = (CW > SW) ? CW : SW;

   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_COUNT, S_REPORT} state_t;

   state_t              state, state_nxt;
   logic signed [31:0]  step_r;
   logic [15:0]         nsteps_r;
   logic [15:0]         idx;
   logic [CW-1:0]       window_r;
   logic [CW-1:0]       count;
   logic [TW-1:0]       timer;

   logic                settle_end;
   logic                count_end;
   logic                last_step;
   logic                hs;
   logic [CW-1:0]       count_inc;
   logic [CW-1:0]       win_m1;

   // A zero window still counts for one cycle
   assign win_m1     = (window_r == '0) ? '0 : window_r - 1'b1;
   assign settle_end = (timer == TW'(SETTLE_CYC - 1));
   assign count_end  = (timer == TW'(win_m1));
   assign hs         = RES_VALID & RES_READY;
   assign last_step  = (idx == nsteps_r - 16'd1);
   assign count_inc  = (LYCALOTRG && (count != '1)) ? count + 1'b1 : count;
   assign BUSY       = (state != S_IDLE);

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (START && (NSTEPS != 16'd0)) state_nxt = S_SETTLE;
         S_SETTLE: if (settle_end) state_nxt = S_COUNT;
         S_COUNT:  if (count_end) state_nxt = S_REPORT;
         S_REPORT: if (hs) state_nxt = last_step ? S_IDLE : S_SETTLE;
         default:  state_nxt = S_IDLE;
      endcase
      if (ABORT) state_nxt = S_IDLE;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state     <= S_IDLE;
         step_r    <= '0;
         nsteps_r  <= '0;
         window_r  <= '0;
         idx       <= '0;
         count     <= '0;
         timer     <= '0;
         LYCALOTHR <= '0;
         RES_VALID <= 1'b0;
         RES_THR   <= '0;
         RES_COUNT <= '0;
         DONE      <= 1'b0;
      end else begin
         state <= state_nxt;
         DONE  <= 1'b0;
         if (ABORT) begin
            RES_VALID <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (START) begin
                     if (NSTEPS == 16'd0) begin
                        DONE <= 1'b1;
                     end else begin
                        step_r    <= THR_STEP;
                        nsteps_r  <= NSTEPS;
                        window_r  <= WINDOW;
                        LYCALOTHR <= THR_START;
                        idx       <= '0;
                        count     <= '0;
                        timer     <= '0;
                     end
                  end
               end
               S_SETTLE: timer <= settle_end ? '0 : timer + 1'b1;
               S_COUNT: begin
                  count <= count_inc;
                  timer <= timer + 1'b1;
                  if (count_end) begin
                     RES_VALID <= 1'b1;
                     RES_THR   <= LYCALOTHR;
                     RES_COUNT <= count_inc;
                     timer     <= '0;
                  end
               end
               S_REPORT: begin
                  if (hs) begin
                     RES_VALID <= 1'b0;
                     if (last_step) begin
                        DONE <= 1'b1;
                     end else begin
                        LYCALOTHR <= LYCALOTHR + step_r;
                        idx       <= idx + 16'd1;
                        count     <= '0;
                        timer     <= '0;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_lycalo_thr_scan.sv
// tb/tb_lycalo_thr_scan.sv - directed self-checking bench for lycalo_thr_scan
module tb_lycalo_thr_scan;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               start = 1'b0;
   logic               start4 = 1'b0;
   logic               abort = 1'b0;
   logic signed [31:0] thr_start = '0;
   logic signed [31:0] thr_step = '0;
   logic [15:0]        nsteps = '0;
   logic [15:0]        window = '0;
   logic               trg_lvl = 1'b0;
   logic               trg_toggle = 1'b0;
   logic               tog = 1'b0;
   logic               trg;
   logic               res_ready = 1'b1;

   logic signed [31:0] lycalothr, res_thr, lycalothr4, res_thr4;
   logic               res_valid, busy, done, res_valid4, busy4, done4;
   logic [15:0]        res_count;
   logic [3:0]         res_count4;

   int tests = 0;
   int failures = 0;

   assign trg = trg_toggle ? tog : trg_lvl;

   always #5 clk = ~clk;
   always @(negedge clk) tog = ~tog;

   lycalo_thr_scan #(.CW(16), .SETTLE_CYC(4)) dut (
      .CLK(clk), .RST(rst), .START(start), .ABORT(abort),
      .THR_START(thr_start), .THR_STEP(thr_step), .NSTEPS(nsteps), .WINDOW(window),
      .LYCALOTRG(trg), .LYCALOTHR(lycalothr), .RES_VALID(res_valid), .RES_READY(res_ready),
      .RES_THR(res_thr), .RES_COUNT(res_count), .BUSY(busy), .DONE(done)
   );

   lycalo_thr_scan #(.CW(4), .SETTLE_CYC(4)) dut4 (
      .CLK(clk), .RST(rst), .START(start4), .ABORT(abort),
      .THR_START(thr_start), .THR_STEP(thr_step), .NSTEPS(nsteps), .WINDOW(window[3:0]),
      .LYCALOTRG(trg), .LYCALOTHR(lycalothr4), .RES_VALID(res_valid4), .RES_READY(res_ready),
      .RES_THR(res_thr4), .RES_COUNT(res_count4), .BUSY(busy4), .DONE(done4)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_valid(input string tag, output int n);
      n = 0;
      while (!res_valid && n < 200) begin
         tick();
         n++;
      end
      chk({tag, "_timeout"}, {31'd0, res_valid}, 32'd1);
   endtask

   task automatic take(input string tag, input logic [31:0] et, input logic [15:0] ec);
      int n;
      wait_valid(tag, n);
      chk({tag, "_thr"}, res_thr, et);
      chk({tag, "_cnt"}, {16'd0, res_count}, {16'd0, ec});
      tick();
   endtask

   initial begin
      int n;
      logic seen;

      // reset state
      repeat (2) @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_valid", {31'd0, res_valid}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_thr", lycalothr, 32'd0);
      chk("rst_rthr", res_thr, 32'd0);
      chk("rst_rcnt", {16'd0, res_count}, 32'd0);
      rst = 1'b0;
      tick();

      // 1: basic three-step scan, exact latency and period
      thr_start = -32'sd10; thr_step = 32'sd10; nsteps = 16'd3; window = 16'd8; trg_lvl = 1'b1;
      pulse_start();
      chk("t1_busy", {31'd0, busy}, 32'd1);
      chk("t1_lthr", lycalothr, 32'hFFFF_FFF6);
      wait_valid("t1_r0", n);
      chk("t1_latency", n, 32'd12);
      chk("t1_r0_thr", res_thr, 32'hFFFF_FFF6);
      chk("t1_r0_cnt", {16'd0, res_count}, 32'd8);
      tick();
      chk("t1_valid_drop", {31'd0, res_valid}, 32'd0);
      chk("t1_lthr_step", lycalothr, 32'd0);
      wait_valid("t1_r1", n);
      chk("t1_period", n, 32'd12);
      chk("t1_r1_thr", res_thr, 32'd0);
      chk("t1_r1_cnt", {16'd0, res_count}, 32'd8);
      tick();
      take("t1_r2", 32'd10, 16'd8);
      chk("t1_done", {31'd0, done}, 32'd1);
      chk("t1_idle", {31'd0, busy}, 32'd0);
      tick();
      chk("t1_done_pulse", {31'd0, done}, 32'd0);
      chk("t1_thr_hold", lycalothr, 32'd10);

      // 2: back-pressure on the first result
      res_ready = 1'b0;
      pulse_start();
      wait_valid("t2_r0", n);
      repeat (5) tick();
      chk("t2_hold_valid", {31'd0, res_valid}, 32'd1);
      chk("t2_hold_thr", res_thr, 32'hFFFF_FFF6);
      chk("t2_hold_cnt", {16'd0, res_count}, 32'd8);
      res_ready = 1'b1;
      tick();
      chk("t2_valid_drop", {31'd0, res_valid}, 32'd0);
      take("t2_r1", 32'd0, 16'd8);
      take("t2_r2", 32'd10, 16'd8);
      chk("t2_done", {31'd0, done}, 32'd1);

      // 3: toggling trigger over WINDOW=10, then triggers only during settle
      tick();
      thr_start = 32'sd5; thr_step = 32'sd1; nsteps = 16'd1; window = 16'd10;
      trg_lvl = 1'b0; trg_toggle = 1'b1;
      pulse_start();
      take("t3_tog", 32'd5, 16'd5);
      trg_toggle = 1'b0;
      tick();
      window = 16'd3;
      trg_lvl = 1'b1;
      pulse_start();
      repeat (3) @(posedge clk);
      tick();
      trg_lvl = 1'b0;
      take("t3_settle", 32'd5, 16'd0);

      // 4: CW=4 saturation boundary and WINDOW=0
      tick();
      trg_lvl = 1'b1; window = 16'd15; nsteps = 16'd1; thr_start = 32'sd3;
      start4 = 1'b1; tick(); start4 = 1'b0;
      n = 0;
      while (!res_valid4 && n < 200) begin tick(); n++; end
      chk("t4_w15_cnt", {28'd0, res_count4}, 32'd15);
      tick();
      tick();
      window = 16'd0;
      start4 = 1'b1; tick(); start4 = 1'b0;
      n = 0;
      while (!res_valid4 && n < 200) begin tick(); n++; end
      chk("t4_w0_lat", n, 32'd5);
      chk("t4_w0_cnt", {28'd0, res_count4}, 32'd1);
      tick();
      chk("t4_done", {31'd0, done4}, 32'd1);

      // 5: abort during counting of step 2
      tick();
      thr_start = 32'sd100; thr_step = -32'sd5; nsteps = 16'd4; window = 16'd6;
      pulse_start();
      take("t5_r0", 32'd100, 16'd6);
      repeat (5) @(posedge clk);
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("t5_busy", {31'd0, busy}, 32'd0);
      chk("t5_valid", {31'd0, res_valid}, 32'd0);
      chk("t5_nodone", {31'd0, done}, 32'd0);
      chk("t5_thr_keep", lycalothr, 32'd95);
      seen = 1'b0;
      repeat (30) begin
         tick();
         if (res_valid || done || busy) seen = 1'b1;
      end
      chk("t5_quiet", {31'd0, seen}, 32'd0);
      thr_start = 32'sd7; nsteps = 16'd1;
      pulse_start();
      take("t5_restart", 32'd7, 16'd6);
      chk("t5_restart_done", {31'd0, done}, 32'd1);

      // 6: threshold wrap and NSTEPS=0
      tick();
      thr_start = 32'sh7FFF_FFFF; thr_step = 32'sd1; nsteps = 16'd2; window = 16'd2;
      pulse_start();
      take("t6_r0", 32'h7FFF_FFFF, 16'd2);
      take("t6_r1", 32'h8000_0000, 16'd2);
      chk("t6_done", {31'd0, done}, 32'd1);
      tick();
      nsteps = 16'd0;
      pulse_start();
      chk("t6_n0_done", {31'd0, done}, 32'd1);
      chk("t6_n0_busy", {31'd0, busy}, 32'd0);
      seen = 1'b0;
      repeat (20) begin
         tick();
         if (res_valid || done) seen = 1'b1;
      end
      chk("t6_n0_quiet", {31'd0, seen}, 32'd0);

      // asynchronous reset mid-scan
      nsteps = 16'd2; window = 16'd8; thr_start = 32'sd42;
      pulse_start();
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("ar_busy", {31'd0, busy}, 32'd0);
      chk("ar_thr", lycalothr, 32'd0);
      chk("ar_valid", {31'd0, res_valid}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (20) tick();
      chk("ar_no_resume", {31'd0, busy | res_valid}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
